// File: rtl/sprite_pkg.sv
// Shared sprite layout definitions: pixel/word geometry, packer FSM states and
// the (x,y) -> (word address, nibble) mapping used by both writer and colour mappers.
package sprite_pkg;

    localparam int PIX_BITS     = 4;
    localparam int PIX_PER_WORD = 8;
    localparam int WORD_BITS    = 32;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] word_addr;
        logic [2:0]  nib;
    } pix_loc_t;

    // Raster-order linear index split into packed word address and nibble slot.
    function automatic pix_loc_t pix_loc(input int unsigned x,
                                         input int unsigned y,
                                         input int unsigned width);
        int unsigned lin;
        pix_loc_t    loc;
        lin           = x + y * width;
        loc.word_addr = 32'(lin / PIX_PER_WORD);
        loc.nib       = 3'(lin % PIX_PER_WORD);
        return loc;
    endfunction

endpackage

// File: rtl/sprite_pixel_packer_if.sv
// Pixel stream in / sprite BRAM write port out of the packer, plus status.
// master = loader/test side, slave = packer.
interface sprite_pixel_packer_if
    import sprite_pkg::*;
#(
    parameter int ADDR_W = 6
);

    logic                 Start;
    logic                 Pix_valid;
    logic [PIX_BITS-1:0]  Pix_data;
    logic                 Pix_ready;
    logic                 Mem_we;
    logic [ADDR_W-1:0]    Mem_addr;
    logic [WORD_BITS-1:0] Mem_wdata;
    logic                 Busy;
    logic                 Done;

    modport master (
        output Start, Pix_valid, Pix_data,
        input  Pix_ready, Mem_we, Mem_addr, Mem_wdata, Busy, Done
    );

    modport slave (
        input  Start, Pix_valid, Pix_data,
        output Pix_ready, Mem_we, Mem_addr, Mem_wdata, Busy, Done
    );

endinterface

// File: rtl/sprite_pixel_packer.sv
// Packs raster-order 4-bit pixels 8-per-word into sprite BRAM from address 0; Mem_we
// one cycle after the completing handshake, 8 px / 9 cycles; Pix_ready low outside FILL.
module sprite_pixel_packer
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 20,
    parameter int SPRITE_H = 20,
    parameter int ADDR_W   = 6
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    sprite_pixel_packer_if.slave   bus
);

    localparam int TOTAL = SPRITE_W * SPRITE_H;
    localparam int WORDS = (TOTAL + PIX_PER_WORD - 1) / PIX_PER_WORD;
    localparam int LAST  = WORDS - 1;
    localparam int CNT_W = $clog2(TOTAL + 1);

    state_t               state, state_n;
    logic [2:0]           nib, nib_n;
    logic [CNT_W-1:0]     pix_cnt, pix_cnt_n;
    logic [WORD_BITS-1:0] pack, pack_n;
    logic [WORD_BITS-1:0] wdata_q, wdata_n;
    logic [ADDR_W-1:0]    word_addr, word_addr_n;
    logic [ADDR_W-1:0]    maddr_q, maddr_n;
    logic                 hs;

    assign hs = (state == FILL) && bus.Pix_valid;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            nib       <= '0;
            pix_cnt   <= '0;
            pack      <= '0;
            wdata_q   <= '0;
            word_addr <= '0;
            maddr_q   <= '0;
        end else begin
            state     <= state_n;
            nib       <= nib_n;
            pix_cnt   <= pix_cnt_n;
            pack      <= pack_n;
            wdata_q   <= wdata_n;
            word_addr <= word_addr_n;
            maddr_q   <= maddr_n;
        end
    end

    always_comb begin
        state_n     = state;
        nib_n       = nib;
        pix_cnt_n   = pix_cnt;
        pack_n      = pack;
        wdata_n     = wdata_q;
        word_addr_n = word_addr;
        maddr_n     = maddr_q;

        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    state_n     = FILL;
                    pack_n      = '0;
                    nib_n       = '0;
                    pix_cnt_n   = '0;
                    word_addr_n = '0;
                end
            end

            FILL: begin
                if (hs) begin
                    pack_n[{nib, 2'b00} +: PIX_BITS] = bus.Pix_data;
                    nib_n     = nib + 3'd1;
                    pix_cnt_n = pix_cnt + CNT_W'(1);
                    // Output registers load here so they only move when a word is due.
                    if (nib == 3'd7 || pix_cnt == CNT_W'(TOTAL - 1)) begin
                        state_n = WRITE;
                        wdata_n = pack_n;
                        maddr_n = word_addr;
                    end
                end
            end

            WRITE: begin
                if (word_addr == ADDR_W'(LAST)) begin
                    state_n = DONE;
                end else begin
                    word_addr_n = word_addr + ADDR_W'(1);
                    pack_n      = '0;
                    nib_n       = '0;
                    state_n     = FILL;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.Pix_ready = (state == FILL);
    assign bus.Mem_we    = (state == WRITE);
    assign bus.Mem_addr  = maddr_q;
    assign bus.Mem_wdata = wdata_q;
    assign bus.Busy      = (state != IDLE);
    assign bus.Done      = (state == DONE);

endmodule

// File: tb/tb_sprite_pixel_packer.sv
// Randomised and directed bench for sprite_pixel_packer: 20x20 and 3x3 instances
// compared against a nibble-packing reference model of the sprite stream.
module tb_sprite_pixel_packer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sprite_pixel_packer_if #(.ADDR_W(6)) ia ();
    sprite_pixel_packer_if #(.ADDR_W(1)) ib ();

    sprite_pixel_packer #(.SPRITE_W(20), .SPRITE_H(20), .ADDR_W(6)) dut_a (
        .Clk(clk), .Reset_n(reset_n), .bus(ia)
    );
    sprite_pixel_packer #(.SPRITE_W(3), .SPRITE_H(3), .ADDR_W(1)) dut_b (
        .Clk(clk), .Reset_n(reset_n), .bus(ib)
    );

    localparam int TOTAL_A = 400;
    localparam int WORDS_A = 50;

    int checks = 0;
    int failures = 0;
    logic [3:0]  pix [TOTAL_A];
    int          got_addr [$];
    logic [31:0] got_data [$];
    int          done_cnt, done_cyc, ready_viol;

    // Reference: word w holds pixels 8w..8w+7, pixel k of the word at nibble k, zero padded.
    function automatic logic [31:0] model_word(input int w, input int total);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < 8; k++)
            if (8 * w + k < total) v = v | (32'(pix[8 * w + k]) << (4 * k));
        return v;
    endfunction

    task automatic run_a(input int mode, input bit issue_start, input bit start_noise,
                         input int exp_done_cyc);
        int cyc, idx;
        bit done_seen, v;
        got_addr.delete(); got_data.delete();
        done_cnt = 0; done_cyc = -1; ready_viol = 0;
        idx = 0; cyc = 0; done_seen = 0;
        if (issue_start) begin
            @(negedge clk); ia.Start = 1'b1;
        end
        while (!done_seen && cyc < 3000) begin
            @(negedge clk); cyc++;
            ia.Start = start_noise && (cyc == 20 || cyc == 21);
            if (ia.Mem_we) begin
                got_addr.push_back(int'(ia.Mem_addr));
                got_data.push_back(ia.Mem_wdata);
                if (ia.Pix_ready) ready_viol++;
            end
            if (ia.Done) begin
                done_cnt++; done_cyc = cyc; done_seen = 1;
                ia.Start = start_noise;
            end
            if (mode == 0)      v = (idx < TOTAL_A);
            else if (mode == 1) v = (idx < TOTAL_A) && (cyc % 3 != 0);
            else                v = (idx < TOTAL_A) && ($urandom_range(0, 3) != 0);
            ia.Pix_valid = v;
            ia.Pix_data  = v ? pix[idx] : 4'($urandom);
            if (v && ia.Pix_ready) idx++;
        end
        checks++;
        if (!done_seen) begin
            failures++; $display("FAIL done_timeout mode=%0d got no Done within %0d cycles", mode, cyc);
        end
        @(negedge clk);
        checks++;
        if (ia.Busy !== 1'b0 || ia.Pix_ready !== 1'b0 || ia.Done !== 1'b0) begin
            failures++;
            $display("FAIL after_done mode=%0d busy=%b ready=%b done=%b expected 0 0 0",
                     mode, ia.Busy, ia.Pix_ready, ia.Done);
        end
        checks++;
        if (got_addr.size() != WORDS_A) begin
            failures++; $display("FAIL write_count mode=%0d got %0d expected %0d", mode, got_addr.size(), WORDS_A);
        end
        for (int w = 0; w < got_addr.size() && w < WORDS_A; w++) begin
            checks++;
            if (got_addr[w] != w || got_data[w] !== model_word(w, TOTAL_A)) begin
                failures++;
                $display("FAIL word mode=%0d idx=%0d got addr=%0d data=%h expected addr=%0d data=%h",
                         mode, w, got_addr[w], got_data[w], w, model_word(w, TOTAL_A));
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++; $display("FAIL done_count mode=%0d got %0d expected 1", mode, done_cnt);
        end
        checks++;
        if (ready_viol != 0) begin
            failures++; $display("FAIL ready_in_write mode=%0d got %0d cycles expected 0", mode, ready_viol);
        end
        if (exp_done_cyc > 0) begin
            checks++;
            if (done_cyc != exp_done_cyc) begin
                failures++; $display("FAIL done_latency mode=%0d got %0d expected %0d", mode, done_cyc, exp_done_cyc);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ia.Pix_ready, ia.Mem_we, ia.Busy, ia.Done} !== 4'b0 || ia.Mem_addr !== 6'd0 || ia.Mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_a got rdy=%b we=%b busy=%b done=%b addr=%0d data=%h expected all 0",
                     ia.Pix_ready, ia.Mem_we, ia.Busy, ia.Done, ia.Mem_addr, ia.Mem_wdata);
        end
        checks++;
        if ({ib.Pix_ready, ib.Mem_we, ib.Busy, ib.Done} !== 4'b0 || ib.Mem_wdata !== 32'd0) begin
            failures++; $display("FAIL reset_b got rdy=%b we=%b busy=%b done=%b expected all 0",
                                 ib.Pix_ready, ib.Mem_we, ib.Busy, ib.Done);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_no_start();
        int viol;
        viol = 0;
        ia.Pix_valid = 1'b1; ia.Pix_data = 4'hF;
        repeat (6) begin
            @(negedge clk);
            if (ia.Pix_ready || ia.Mem_we || ia.Busy) viol++;
        end
        ia.Pix_valid = 1'b0;
        checks++;
        if (viol != 0) begin
            failures++; $display("FAIL idle_no_start got %0d active cycles expected 0", viol);
        end
    endtask

    task automatic test_full_stream();
        for (int i = 0; i < TOTAL_A; i++) pix[i] = 4'(i % 16);
        run_a(0, 1'b1, 1'b0, 451);
        checks++;
        if (got_data.size() < 2 || got_data[0] !== 32'h76543210 || got_data[1] !== 32'hFEDCBA98) begin
            failures++;
            $display("FAIL first_words got %h %h expected 76543210 fedcba98",
                     got_data.size() > 0 ? got_data[0] : 32'hx, got_data.size() > 1 ? got_data[1] : 32'hx);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < TOTAL_A; i++) pix[i] = 4'(i % 16);
        run_a(1, 1'b1, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < TOTAL_A; i++) pix[i] = 4'($urandom);
        run_a(2, 1'b1, 1'b0, 0);
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < TOTAL_A; i++) pix[i] = 4'($urandom);
        run_a(0, 1'b1, 1'b1, 451);
        run_a(0, 1'b0, 1'b0, 451);
    endtask

    task automatic test_reset_mid();
        int idx, cyc, nwr;
        logic [31:0] w0;
        for (int i = 0; i < TOTAL_A; i++) pix[i] = 4'(i % 16);
        idx = 0; cyc = 0; nwr = 0; w0 = 32'h0;
        @(negedge clk); ia.Start = 1'b1;
        while (idx < 13 && cyc < 200) begin
            @(negedge clk); cyc++;
            ia.Start = 1'b0;
            if (ia.Mem_we) begin nwr++; if (nwr == 1) w0 = ia.Mem_wdata; end
            ia.Pix_valid = 1'b1; ia.Pix_data = pix[idx];
            if (ia.Pix_ready) idx++;
        end
        @(negedge clk);
        if (ia.Mem_we) nwr++;
        ia.Pix_valid = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ia.Pix_ready, ia.Mem_we, ia.Busy, ia.Done} !== 4'b0 || ia.Mem_addr !== 6'd0 || ia.Mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs got rdy=%b we=%b busy=%b done=%b addr=%0d data=%h expected all 0",
                     ia.Pix_ready, ia.Mem_we, ia.Busy, ia.Done, ia.Mem_addr, ia.Mem_wdata);
        end
        checks++;
        if (nwr != 1 || w0 !== model_word(0, TOTAL_A)) begin
            failures++; $display("FAIL reset_mid_writes got %0d writes word0=%h expected 1 write %h",
                                 nwr, w0, model_word(0, TOTAL_A));
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_a(0, 1'b1, 1'b0, 451);
    endtask

    task automatic test_small_sprite();
        int cyc, idx, dcyc;
        int          a_q [$];
        logic [31:0] d_q [$];
        bit seen;
        cyc = 0; idx = 0; dcyc = -1; seen = 0;
        @(negedge clk); ib.Start = 1'b1;
        while (!seen && cyc < 100) begin
            @(negedge clk); cyc++;
            ib.Start = 1'b0;
            if (ib.Mem_we) begin a_q.push_back(int'(ib.Mem_addr)); d_q.push_back(ib.Mem_wdata); end
            if (ib.Done) begin seen = 1; dcyc = cyc; end
            ib.Pix_valid = (idx < 9);
            ib.Pix_data  = 4'(idx + 1);
            if (ib.Pix_valid && ib.Pix_ready) idx++;
        end
        ib.Pix_valid = 1'b0;
        checks++;
        if (a_q.size() != 2) begin
            failures++; $display("FAIL small_count got %0d writes expected 2", a_q.size());
        end else begin
            checks++;
            if (a_q[0] != 0 || d_q[0] !== 32'h87654321) begin
                failures++; $display("FAIL small_word0 got addr=%0d data=%h expected 0 87654321", a_q[0], d_q[0]);
            end
            checks++;
            if (a_q[1] != 1 || d_q[1] !== 32'h00000009) begin
                failures++; $display("FAIL small_word1 got addr=%0d data=%h expected 1 00000009", a_q[1], d_q[1]);
            end
        end
        checks++;
        if (dcyc != 12) begin
            failures++; $display("FAIL small_done got cycle %0d expected 12", dcyc);
        end
        @(negedge clk);
        checks++;
        if (ib.Busy !== 1'b0) begin
            failures++; $display("FAIL small_busy got %b expected 0", ib.Busy);
        end
    endtask

    initial begin
        ia.Start = 1'b0; ia.Pix_valid = 1'b0; ia.Pix_data = 4'h0;
        ib.Start = 1'b0; ib.Pix_valid = 1'b0; ib.Pix_data = 4'h0;
        test_reset();
        test_idle_no_start();
        test_full_stream();
        test_stall();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_small_sprite();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
